// File: rtl/ulpi_pkg.sv
// Shared ULPI definitions: register-engine state encoding and TXCMD header fields.
// Intended to be reused by the ULPI RX/TX blocks.
package ulpi_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_WAITBUS = 4'd1,
      ST_TXCMD   = 4'd2,
      ST_EXTADDR = 4'd3,
      ST_WDATA   = 4'd4,
      ST_WSTP    = 4'd5,
      ST_TA1     = 4'd6,
      ST_RDATA   = 4'd7,
      ST_TA2     = 4'd8,
      ST_ABORT   = 4'd9,
      ST_DONE    = 4'd10,
      ST_ERR     = 4'd11
   } ulpi_state_e;

   localparam logic [1:0] CMD_REG_WR    = 2'b10;
   localparam logic [1:0] CMD_REG_RD    = 2'b11;
   localparam logic [5:0] EXT_ADDR_CODE = 6'h2F;
   localparam logic [7:0] EXT_ADDR_MIN  = 8'h3F;

   // Immediate access carries the address in the TXCMD; extended access carries the escape code.
   function automatic logic [7:0] txcmd_byte(input logic we, input logic ext, input logic [7:0] a);
      logic [1:0] hdr;
      logic [5:0] fld;
      hdr = we  ? CMD_REG_WR : CMD_REG_RD;
      fld = ext ? EXT_ADDR_CODE : a[5:0];
      return {hdr, fld};
   endfunction

endpackage

// File: rtl/ulpi_timeout_cnt.sv
// Saturating wait counter for NXT handshakes; expired after TIMEOUT_CYC-1 counted cycles
// so the owning FSM leaves its state on the TIMEOUT_CYC-th edge after entry.
module ulpi_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q >= LIMIT);

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (en && !expired)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ulpi_reg_access.sv
// ULPI PHY register engine: immediate/extended register read and write with DIR-abort retry,
// NXT timeout and done/err status. All bus outputs are registered from the next-state decode.
module ulpi_reg_access
   import ulpi_pkg::*;
#(
   parameter bit          EXT_ADDR_EN = 1'b1,
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic       clk_ULPI,
   input  logic       rst,
   input  logic       req,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] rdata,
   input  logic       DIR,
   input  logic       NXT,
   input  logic [7:0] DATA_I,
   output logic [7:0] DATA_O,
   output logic       DATA_OE,
   output logic       STP
);

   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   ulpi_state_e state_q, state_d;
   logic          we_q, we_d, ext_q, ext_d;
   logic [7:0]    addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [7:0]    data_o_q, data_o_d;
   logic          oe_q, oe_d, stp_q, stp_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic          req_ext, tmo_clear, tmo_en, tmo_expired;

   assign req_ext   = (addr >= EXT_ADDR_MIN);
   assign tmo_clear = (state_d != state_q);
   assign tmo_en    = (state_q == ST_TXCMD) || (state_q == ST_EXTADDR) || (state_q == ST_WDATA);

   ulpi_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
      .clk     (clk_ULPI),
      .rst_n   (rst),
      .clear   (tmo_clear),
      .en      (tmo_en),
      .expired (tmo_expired)
   );

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      ext_d   = ext_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      retry_d = retry_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            retry_d = '0;
            if (req) begin
               we_d    = we;
               ext_d   = req_ext;
               addr_d  = addr;
               wdata_d = wdata;
               if (req_ext && !EXT_ADDR_EN) state_d = ST_ERR;
               else if (DIR)                state_d = ST_WAITBUS;
               else                         state_d = ST_TXCMD;
            end
         end
         ST_WAITBUS: if (!DIR) state_d = ST_TXCMD;
         ST_TXCMD: begin
            if (DIR)              state_d = ST_ABORT;
            else if (NXT)         state_d = ext_q ? ST_EXTADDR : (we_q ? ST_WDATA : ST_TA1);
            else if (tmo_expired) state_d = ST_ERR;
         end
         ST_EXTADDR: begin
            if (DIR)              state_d = ST_ABORT;
            else if (NXT)         state_d = we_q ? ST_WDATA : ST_TA1;
            else if (tmo_expired) state_d = ST_ERR;
         end
         ST_WDATA: begin
            if (DIR)              state_d = ST_ABORT;
            else if (NXT)         state_d = ST_WSTP;
            else if (tmo_expired) state_d = ST_ERR;
         end
         ST_WSTP: state_d = ST_DONE;
         ST_TA1:  state_d = ST_RDATA;
         ST_RDATA: begin
            if (DIR && !NXT) begin
               rdata_d = DATA_I;
               state_d = ST_TA2;
            end else begin
               state_d = ST_ABORT;
            end
         end
         ST_TA2: if (!DIR) state_d = ST_DONE;
         ST_ABORT: begin
            if (!DIR) begin
               if (32'(retry_q) < MAX_RETRY) begin
                  retry_d = retry_q + 1'b1;
                  state_d = ST_TXCMD;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_DONE, ST_ERR: state_d = ST_IDLE;
         default:         state_d = ST_IDLE;
      endcase
   end

   // Outputs decode the next state so every pin is a flop and OE drops on the edge that sees DIR.
   always_comb begin
      data_o_d = '0;
      oe_d     = 1'b0;
      stp_d    = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      busy_d   = 1'b1;
      case (state_d)
         ST_IDLE: busy_d = 1'b0;
         ST_TXCMD: begin
            oe_d     = 1'b1;
            data_o_d = txcmd_byte(we_d, ext_d, addr_d);
         end
         ST_EXTADDR: begin
            oe_d     = 1'b1;
            data_o_d = addr_d;
         end
         ST_WDATA: begin
            oe_d     = 1'b1;
            data_o_d = wdata_d;
         end
         ST_WSTP: begin
            oe_d  = 1'b1;
            stp_d = 1'b1;
         end
         ST_DONE: begin
            done_d = 1'b1;
            busy_d = 1'b0;
         end
         ST_ERR: begin
            err_d  = 1'b1;
            busy_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_ULPI or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         ext_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         retry_q  <= '0;
         data_o_q <= '0;
         oe_q     <= 1'b0;
         stp_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         ext_q    <= ext_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         retry_q  <= retry_d;
         data_o_q <= data_o_d;
         oe_q     <= oe_d;
         stp_q    <= stp_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign rdata   = rdata_q;
   assign DATA_O  = data_o_q;
   assign DATA_OE = oe_q;
   assign STP     = stp_q;

endmodule

// File: tb/tb_ulpi_reg_access.sv
// Directed bench for ulpi_reg_access: write, read, extended read, DIR abort/retry,
// NXT timeout, bus wait and asynchronous reset, with hand-computed expectations.
module tb_ulpi_reg_access;

   logic       clk_ULPI = 1'b0;
   logic       rst = 1'b0;
   logic       req = 1'b0, req2 = 1'b0, we = 1'b0;
   logic [7:0] addr = '0, wdata = '0, DATA_I = '0;
   logic       DIR = 1'b0, NXT = 1'b0;
   logic       busy, done, err, DATA_OE, STP;
   logic [7:0] rdata, DATA_O;
   logic       busy2, done2, err2, DATA_OE2, STP2;
   logic [7:0] rdata2, DATA_O2;
   logic       oe2_seen = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_ULPI = ~clk_ULPI;

   ulpi_reg_access #(.EXT_ADDR_EN(1'b1), .TIMEOUT_CYC(64), .MAX_RETRY(1)) dut (
      .clk_ULPI(clk_ULPI), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .err(err), .rdata(rdata),
      .DIR(DIR), .NXT(NXT), .DATA_I(DATA_I), .DATA_O(DATA_O), .DATA_OE(DATA_OE), .STP(STP)
   );

   ulpi_reg_access #(.EXT_ADDR_EN(1'b0), .TIMEOUT_CYC(64), .MAX_RETRY(1)) dut_noext (
      .clk_ULPI(clk_ULPI), .rst(rst), .req(req2), .we(we), .addr(addr), .wdata(wdata),
      .busy(busy2), .done(done2), .err(err2), .rdata(rdata2),
      .DIR(DIR), .NXT(NXT), .DATA_I(DATA_I), .DATA_O(DATA_O2), .DATA_OE(DATA_OE2), .STP(STP2)
   );

   always @(posedge clk_ULPI) if (DATA_OE2) oe2_seen = 1'b1;

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_ULPI);
      #1;
   endtask

   task automatic start(input logic w, input logic [7:0] a, input logic [7:0] d);
      req = 1'b1; we = w; addr = a; wdata = d;
      tick;
      req = 1'b0;
   endtask

   initial begin
      tick; tick;
      chk("rst_busy", busy, 0);   chk("rst_done", done, 0);  chk("rst_err", err, 0);
      chk("rst_oe", DATA_OE, 0);  chk("rst_stp", STP, 0);    chk("rst_data", DATA_O, 0);
      chk("rst_rdata", rdata, 0);
      rst = 1'b1;
      tick;

      // Write 0x0A <- 0x55, NXT immediate; a second req mid-access must be ignored.
      DIR = 0; NXT = 1;
      start(1'b1, 8'h0A, 8'h55);
      chk("wr_txcmd", DATA_O, 8'h8A); chk("wr_oe", DATA_OE, 1); chk("wr_busy", busy, 1);
      req = 1'b1; we = 1'b0; addr = 8'h33; wdata = 8'h99;
      tick; req = 1'b0;
      chk("wr_wdata", DATA_O, 8'h55);
      tick;
      chk("wr_stp", STP, 1); chk("wr_stp_data", DATA_O, 0); chk("wr_stp_oe", DATA_OE, 1);
      tick;
      chk("wr_done", done, 1); chk("wr_stp_off", STP, 0); chk("wr_oe_off", DATA_OE, 0);
      chk("wr_busy_off", busy, 0);
      tick;
      chk("wr_done_pulse", done, 0); chk("wr_idle_busy", busy, 0);

      // Read 0x16, PHY returns 0xA5 (6-cycle latency with a one-cycle DIR turnaround).
      DIR = 0; NXT = 1;
      start(1'b0, 8'h16, 8'h00);
      chk("rd_txcmd", DATA_O, 8'hD6); chk("rd_oe", DATA_OE, 1);
      tick;
      chk("rd_ta1_oe", DATA_OE, 0); chk("rd_ta1_data", DATA_O, 0);
      NXT = 0; DIR = 1; DATA_I = 8'hA5;
      tick;
      chk("rd_rdata_hold", rdata, 8'h00);
      tick;
      chk("rd_capture", rdata, 8'hA5); chk("rd_ta2_done", done, 0);
      tick;
      chk("rd_turn_done", done, 0); chk("rd_turn_busy", busy, 1);
      DIR = 0;
      tick;
      chk("rd_done", done, 1); chk("rd_err", err, 0); chk("rd_value", rdata, 8'hA5);
      tick;

      // Extended read 0x80; the EXT_ADDR_EN=0 instance must reject it without touching the bus.
      DIR = 0; NXT = 1; req2 = 1'b1;
      start(1'b0, 8'h80, 8'h00);
      req2 = 1'b0;
      chk("ext_txcmd", DATA_O, 8'hEF); chk("noext_err", err2, 1); chk("noext_busy", busy2, 0);
      tick;
      chk("ext_addr", DATA_O, 8'h80); chk("ext_addr_oe", DATA_OE, 1); chk("noext_err_pulse", err2, 0);
      tick;
      chk("ext_ta1_oe", DATA_OE, 0);
      NXT = 0; DIR = 1; DATA_I = 8'h3C;
      tick; tick;
      chk("ext_capture", rdata, 8'h3C);
      tick;
      DIR = 0;
      tick;
      chk("ext_done", done, 1);
      tick;

      // DIR interrupts TXCMD once: abort, retry, then a successful read of 0x5A.
      DIR = 0; NXT = 0;
      start(1'b0, 8'h05, 8'h00);
      chk("ab1_txcmd", DATA_O, 8'hC5);
      DIR = 1;
      tick;
      chk("ab1_oe_drop", DATA_OE, 0); chk("ab1_busy", busy, 1);
      DIR = 0;
      tick;
      chk("ab1_retry_txcmd", DATA_O, 8'hC5); chk("ab1_retry_oe", DATA_OE, 1);
      NXT = 1;
      tick;
      NXT = 0; DIR = 1; DATA_I = 8'h5A;
      tick; tick;
      DIR = 0;
      tick;
      chk("ab1_done", done, 1); chk("ab1_rdata", rdata, 8'h5A);
      tick;

      // Two aborts with MAX_RETRY=1: err, rdata keeps 0x5A.
      DIR = 0; NXT = 0; DATA_I = 8'hFF;
      start(1'b0, 8'h05, 8'h00);
      DIR = 1; tick; DIR = 0; tick;
      chk("ab2_retry_oe", DATA_OE, 1);
      DIR = 1; tick;
      chk("ab2_oe_drop", DATA_OE, 0);
      DIR = 0; tick;
      chk("ab2_err", err, 1); chk("ab2_no_done", done, 0); chk("ab2_rdata", rdata, 8'h5A);
      tick;
      chk("ab2_err_pulse", err, 0);

      // NXT never arrives: err exactly 64 cycles after TXCMD entry.
      DIR = 0; NXT = 0;
      start(1'b1, 8'h01, 8'h11);
      for (int i = 0; i < 63; i++) tick;
      chk("tmo_early_err", err, 0); chk("tmo_early_oe", DATA_OE, 1);
      tick;
      chk("tmo_err", err, 1); chk("tmo_oe", DATA_OE, 0);
      tick;
      chk("tmo_err_pulse", err, 0); chk("tmo_oe_after", DATA_OE, 0);

      // PHY owns the bus at request time: wait for DIR low before TXCMD.
      DIR = 1; NXT = 0;
      start(1'b1, 8'h0C, 8'h34);
      chk("wb_oe", DATA_OE, 0); chk("wb_busy", busy, 1);
      tick;
      chk("wb_oe_hold", DATA_OE, 0);
      DIR = 0;
      tick;
      chk("wb_txcmd", DATA_O, 8'h8C);
      NXT = 1;
      tick; chk("wb_wdata", DATA_O, 8'h34);
      tick; tick;
      chk("wb_done", done, 1);
      tick;

      // Asynchronous reset in WDATA, then a normal write.
      DIR = 0; NXT = 1;
      start(1'b1, 8'h0A, 8'h77);
      tick;
      chk("rs_wdata", DATA_O, 8'h77);
      #2 rst = 1'b0;
      #1;
      chk("rs_data", DATA_O, 0); chk("rs_oe", DATA_OE, 0); chk("rs_busy", busy, 0);
      chk("rs_rdata", rdata, 0);
      tick;
      rst = 1'b1;
      tick;
      start(1'b1, 8'h0B, 8'h12);
      chk("rs2_txcmd", DATA_O, 8'h8B);
      tick; chk("rs2_wdata", DATA_O, 8'h12);
      tick; chk("rs2_stp", STP, 1);
      tick; chk("rs2_done", done, 1);
      tick;

      chk("noext_oe_never", oe2_seen, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
